// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to multi-target APB4 bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } bridge_state_t;

    // Largest legal hsize (log2 of bytes) for a given data width.
    function automatic logic [2:0] max_hsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_mp_if.sv
// AHB-Lite slave side and APB4 master side signals of the bridge.
// "slave" is the bridge view, "master" is the view of the AHB master plus APB targets.
interface ahb2apb_bridge_mp_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    import ahb_apb_pkg::*;

    // AHB-Lite
    htrans_t                         htrans;
    logic                            hwrite;
    logic [2:0]                      hsize;
    logic [ADDR_W-1:0]               haddr;
    logic [DATA_W-1:0]               hwdata;
    logic                            hready_in;
    logic                            hready_out;
    logic [1:0]                      hresp;
    logic [DATA_W-1:0]               hrdata;

    // APB4
    logic [ADDR_W-1:0]               paddr;
    logic                            pwrite;
    logic [DATA_W-1:0]               pwdata;
    logic [DATA_W/8-1:0]             pstrb;
    logic [NUM_SLV-1:0]              psel;
    logic                            penable;
    logic [NUM_SLV-1:0][DATA_W-1:0]  prdata;
    logic [NUM_SLV-1:0]              pready;
    logic [NUM_SLV-1:0]              pslverr;

    modport slave (
        input  htrans, hwrite, hsize, haddr, hwdata, hready_in,
        output hready_out, hresp, hrdata,
        output paddr, pwrite, pwdata, pstrb, psel, penable,
        input  prdata, pready, pslverr
    );

    modport master (
        output htrans, hwrite, hsize, haddr, hwdata, hready_in,
        input  hready_out, hresp, hrdata,
        input  paddr, pwrite, pwdata, pstrb, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/ahb_apb_strb_gen.sv
// APB4 byte-strobe generation: a run of 2^hsize lanes starting at the
// byte offset of the address; all strobes are zero for reads.
module ahb_apb_strb_gen #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                    hsize,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic                          hwrite,
    output logic [DATA_W/8-1:0]           strb
);
    localparam int LANES = DATA_W / 8;

    // set each lane that falls inside [addr_lo, addr_lo + 2^hsize)
    always_comb begin
        strb = '0;
        for (int b = 0; b < LANES; b++) begin
            if (hwrite && (b >= int'(addr_lo)) && (b < int'(addr_lo) + (1 << hsize)))
                strb[b] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite slave to multi-target APB4 master bridge with address/size
// checking, PSLVERR-to-ERROR mapping and a PREADY timeout.
module ahb2apb_bridge_mp
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input logic               clock,
    input logic               hresetn,
    ahb2apb_bridge_mp_if.slave bus
);
    localparam int                LO_W     = $clog2(DATA_W / 8);
    localparam logic [2:0]        MAX_HS   = max_hsize(DATA_W);
    localparam int                SEL_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W:0]    SLV_LIM  = (SEL_W + 1)'(NUM_SLV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

    bridge_state_t      state, nstate;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [2:0]         size_q;
    logic [SEL_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q, rdata_q;
    logic [CNT_W-1:0]   cnt;

    logic [SEL_W-1:0]   idx_in;
    logic [ADDR_W-1:0]  align_mask;
    logic               bad, acc;
    logic [NUM_SLV-1:0] sel_oh;
    logic               sel_rdy, sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               hready_c, penable_c;
    logic [1:0]         hresp_c;
    logic [NUM_SLV-1:0] psel_c;

    // with a single target there is no index field and everything decodes to target 0
    assign idx_in     = (NUM_SLV > 1) ? bus.haddr[SEL_LSB +: SEL_W] : '0;
    assign align_mask = (ADDR_W'(1) << bus.hsize) - ADDR_W'(1);
    assign bad        = ({1'b0, idx_in} >= SLV_LIM) || (bus.hsize > MAX_HS) ||
                        ((bus.haddr & align_mask) != '0);

    // selected-target view built from a one-hot mask so non-power-of-two
    // target counts never index past the port arrays
    assign sel_oh  = NUM_SLV'(1) << idx_q;
    assign sel_rdy = |(bus.pready & sel_oh);
    assign sel_err = |(bus.pslverr & sel_oh);

    // read-data mux for the selected target
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel_oh[i]) sel_rdata = bus.prdata[i];
    end

    // state register
    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn) state <= S_IDLE;
        else          state <= nstate;
    end

    // next state and state-decoded bus outputs
    always_comb begin
        nstate    = state;
        acc       = 1'b0;
        hready_c  = 1'b0;
        hresp_c   = HRESP_OKAY;
        psel_c    = '0;
        penable_c = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                hready_c = 1'b1;
                if (state == S_ERR2) hresp_c = HRESP_ERROR;
                acc = bus.hready_in & bus.htrans[1];
                if (!acc)     nstate = S_IDLE;
                else if (bad) nstate = S_ERR1;
                else          nstate = bus.hwrite ? S_WWAIT : S_SETUP;
            end
            S_WWAIT: nstate = S_SETUP;
            S_SETUP: begin
                psel_c = sel_oh;
                nstate = S_ACCESS;
            end
            S_ACCESS: begin
                psel_c    = sel_oh;
                penable_c = 1'b1;
                if (sel_rdy)              nstate = sel_err ? S_ERR1 : S_DONE;
                else if (cnt == CNT_LAST) nstate = S_ERR1;
            end
            S_ERR1: begin
                hresp_c = HRESP_ERROR;
                nstate  = S_ERR2;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // address-phase capture on every accepted transfer
    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            idx_q   <= '0;
        end else if (acc) begin
            addr_q  <= bus.haddr;
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
            idx_q   <= idx_in;
        end
    end

    // write data taken in the AHB data phase; read data held until the next good read
    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn) begin
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == S_WWAIT) wdata_q <= bus.hwdata;
            if (state == S_ACCESS && sel_rdy && !sel_err && !write_q) rdata_q <= sel_rdata;
        end
    end

    // saturating count of ACCESS cycles, restarted from SETUP
    always_ff @(posedge clock or negedge hresetn) begin
        if (!hresetn)                                  cnt <= '0;
        else if (state == S_SETUP)                     cnt <= '0;
        else if (state == S_ACCESS && cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);
    end

    ahb_apb_strb_gen #(.DATA_W(DATA_W)) u_strb (
        .hsize   (size_q),
        .addr_lo (addr_q[LO_W-1:0]),
        .hwrite  (write_q),
        .strb    (bus.pstrb)
    );

    assign bus.hready_out = hready_c;
    assign bus.hresp      = hresp_c;
    assign bus.hrdata     = rdata_q;
    assign bus.paddr      = addr_q;
    assign bus.pwrite     = write_q;
    assign bus.pwdata     = wdata_q;
    assign bus.psel       = psel_c;
    assign bus.penable    = penable_c;

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Self-checking bench: directed cases plus randomized transfers checked
// cycle by cycle against a latency/response model of the bridge.
module tb_ahb2apb_bridge_mp;
    import ahb_apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 8;

    logic clock   = 1'b0;
    logic hresetn = 1'b0;
    always #5 clock = ~clock;

    ahb2apb_bridge_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();
    ahb2apb_bridge_mp_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(5))  bus5 ();

    ahb2apb_bridge_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SEL_LSB(12), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .hresetn (hresetn),
        .bus     (bus)
    );

    ahb2apb_bridge_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(5), .SEL_LSB(12), .TIMEOUT(TO)) dut5 (
        .clock   (clock),
        .hresetn (hresetn),
        .bus     (bus5)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one transfer from its address phase to its final (hready_out=1) cycle
    task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic err);
        logic       bad, to, fail, apb_ph, e_rdy, e_en;
        logic [3:0] oh, estrb, e_sel;
        logic [1:0] e_resp;
        int         wc, na, total, j;
        bad   = (sz > 3'd2) || ((addr % (32'd1 << sz)) != 0);
        to    = !bad && (waits >= TO);
        fail  = !bad && (to || err);
        wc    = w ? 1 : 0;
        na    = to ? TO : waits + 1;
        total = bad ? 2 : wc + 1 + na + (fail ? 2 : 1);
        oh    = 4'(1 << addr[13:12]);
        estrb = (w && !bad) ? 4'(((1 << (1 << sz)) - 1) << addr[1:0]) : 4'b0;

        bus.htrans    = HT_NONSEQ;
        bus.hwrite    = w;
        bus.hsize     = sz;
        bus.haddr     = addr;
        bus.hready_in = 1'b1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clock);
            e_rdy = 1'b0; e_resp = HRESP_OKAY; e_sel = '0; e_en = 1'b0; apb_ph = 1'b0; j = 0;
            if (bad) begin
                e_rdy  = (c == 2);
                e_resp = HRESP_ERROR;
            end else if (c <= wc) begin
                e_rdy = 1'b0;
            end else if (c == wc + 1) begin
                e_sel = oh; apb_ph = 1'b1;
            end else if (c <= wc + 1 + na) begin
                e_sel = oh; e_en = 1'b1; apb_ph = 1'b1; j = c - wc - 1;
            end else if (fail) begin
                e_rdy  = (c == total);
                e_resp = HRESP_ERROR;
            end else begin
                e_rdy = 1'b1;
                if (!w) m_rdata = rd;
            end
            chk("hready_out", bus.hready_out, e_rdy);
            chk("hresp",      bus.hresp,      e_resp);
            chk("psel",       bus.psel,       e_sel);
            chk("penable",    bus.penable,    e_en);
            chk("hrdata",     bus.hrdata,     m_rdata);
            if (apb_ph) begin
                chk("paddr",  bus.paddr,  addr);
                chk("pwrite", bus.pwrite, w);
                chk("pstrb",  bus.pstrb,  estrb);
                if (w) chk("pwdata", bus.pwdata, wd);
            end
            // inputs for the coming edge: junk address phase, random target noise
            if (c == 1) begin
                bus.htrans = HT_IDLE;
                bus.haddr  = $urandom;
                bus.hwrite = 1'($urandom);
                bus.hsize  = 3'($urandom);
            end
            bus.hwdata  = (c == 1 && w) ? wd : $urandom;
            bus.pready  = 4'($urandom);
            bus.pslverr = 4'($urandom);
            for (int i = 0; i < NS; i++) bus.prdata[i] = $urandom;
            if (j > 0) begin
                for (int i = 0; i < NS; i++) begin
                    if (oh[i]) begin
                        bus.pready[i]  = !to && (j == waits + 1);
                        bus.pslverr[i] = (j == waits + 1) ? err : 1'($urandom);
                        bus.prdata[i]  = rd;
                    end
                end
            end
        end
    endtask

    // non-accepting cycles: IDLE, BUSY, or NONSEQ without hready_in
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(2))
                0:       begin bus.htrans = HT_IDLE;   bus.hready_in = 1'($urandom); end
                1:       begin bus.htrans = HT_BUSY;   bus.hready_in = 1'b1; end
                default: begin bus.htrans = HT_NONSEQ; bus.hready_in = 1'b0; end
            endcase
            bus.haddr  = $urandom;
            bus.hwrite = 1'($urandom);
            @(negedge clock);
            chk("idle_hready", bus.hready_out, 1'b1);
            chk("idle_hresp",  bus.hresp,      HRESP_OKAY);
            chk("idle_psel",   bus.psel,       4'b0);
            chk("idle_hrdata", bus.hrdata,     m_rdata);
        end
        bus.hready_in = 1'b1;
    endtask

    // read on the five-target instance; e_sel == 0 means a decode error is expected
    task automatic x5(input logic [31:0] addr, input logic [4:0] e_sel);
        logic [31:0] rd;
        int          n;
        rd = $urandom;
        n  = (e_sel == 5'b0) ? 2 : 3;
        bus5.htrans = HT_NONSEQ; bus5.hwrite = 1'b0; bus5.hsize = 3'd2;
        bus5.haddr  = addr;      bus5.hready_in = 1'b1;
        bus5.pready = '1;        bus5.pslverr = '0;
        for (int i = 0; i < 5; i++) bus5.prdata[i] = e_sel[i] ? rd : $urandom;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            bus5.htrans = HT_IDLE;
            if (n == 2) begin
                chk("dec_hready", bus5.hready_out, c == 2);
                chk("dec_hresp",  bus5.hresp,      HRESP_ERROR);
                chk("dec_psel",   bus5.psel,       5'b0);
            end else begin
                chk("n5_hready", bus5.hready_out, c == 3);
                chk("n5_psel",   bus5.psel,       (c < 3) ? e_sel : 5'b0);
                chk("n5_penable", bus5.penable,   c == 2);
                if (c == 3) chk("n5_hrdata", bus5.hrdata, rd);
            end
        end
    endtask

    initial begin
        bus.htrans = HT_IDLE; bus.hwrite = 1'b0; bus.hsize = '0; bus.haddr = '0;
        bus.hwdata = '0; bus.hready_in = 1'b1;
        bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
        bus5.htrans = HT_IDLE; bus5.hwrite = 1'b0; bus5.hsize = '0; bus5.haddr = '0;
        bus5.hwdata = '0; bus5.hready_in = 1'b1;
        bus5.prdata = '0; bus5.pready = '0; bus5.pslverr = '0;

        // reset values
        repeat (2) @(negedge clock);
        chk("rst_hready",  bus.hready_out, 1'b1);
        chk("rst_hresp",   bus.hresp,      2'b00);
        chk("rst_hrdata",  bus.hrdata,     32'h0);
        chk("rst_paddr",   bus.paddr,      32'h0);
        chk("rst_pwrite",  bus.pwrite,     1'b0);
        chk("rst_pwdata",  bus.pwdata,     32'h0);
        chk("rst_pstrb",   bus.pstrb,      4'h0);
        chk("rst_psel",    bus.psel,       4'h0);
        chk("rst_penable", bus.penable,    1'b0);
        hresetn = 1'b1;
        idle(2);

        // directed cases
        xfer(1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        idle(1);
        xfer(1'b1, 3'd1, 32'h0000_2002, 32'h1234_0000, 32'h0, 0, 1'b0);
        idle(1);
        xfer(1'b0, 3'd2, 32'h0000_0000, 32'h0, 32'h5555_AAAA, 0, 1'b1);
        idle(1);
        xfer(1'b0, 3'd3, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
        xfer(1'b0, 3'd2, 32'h0000_1001, 32'h0, 32'h0, 0, 1'b0);
        idle(1);
        xfer(1'b0, 3'd2, 32'h0000_3000, 32'h0, 32'h0, 20, 1'b0);
        idle(1);
        xfer(1'b1, 3'd2, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
        xfer(1'b0, 3'd2, 32'h0000_3010, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        idle(1);

        // reset asserted during ACCESS
        bus.htrans = HT_NONSEQ; bus.hwrite = 1'b0; bus.hsize = 3'd2;
        bus.haddr = 32'h0000_3008; bus.hready_in = 1'b1; bus.pready = '0;
        @(negedge clock);
        bus.htrans = HT_IDLE;
        @(negedge clock);
        chk("pre_rst_penable", bus.penable, 1'b1);
        #2 hresetn = 1'b0;
        #1;
        chk("mid_rst_psel",    bus.psel,       4'h0);
        chk("mid_rst_penable", bus.penable,    1'b0);
        chk("mid_rst_hready",  bus.hready_out, 1'b1);
        chk("mid_rst_hresp",   bus.hresp,      2'b00);
        m_rdata = '0;
        @(negedge clock);
        hresetn = 1'b1;
        idle(1);

        // decode on a non-power-of-two target count
        x5(32'h0000_5000, 5'b0);
        x5(32'h0000_4000, 5'b10000);
        x5(32'h0000_7000, 5'b0);

        // randomized transfers, mixing back-to-back and gapped issue
        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            int          wt;
            a  = {$urandom_range(15), 2'($urandom_range(3)), 12'($urandom)};
            wt = ($urandom_range(9) == 0) ? TO + $urandom_range(3) : $urandom_range(3);
            xfer(1'($urandom), 3'($urandom_range(3)), a, $urandom, $urandom, wt,
                 $urandom_range(5) == 0);
            if ($urandom_range(1) == 1) idle($urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
